slave_arbiter: RTL and testbench
================================

SLAVE_ARBITER -- requirements
Module: slave_arbiter

Interface
REQ-001 Parameter SLAVE_ID, default 0, meaning: this block serves requests whose master_x_addr[31] equals SLAVE_ID.
REQ-002 Parameter TIMEOUT, default 255, meaning: maximum cycles a transaction waits for slave_ack or slave_resp before it is aborted.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 master_0_req, master_1_req  input  1 each  request from master 0/1.
REQ-006 master_0_addr, master_1_addr  input  32 each  request address; bit 31 selects the slave.
REQ-007 master_0_cmd, master_1_cmd  input  1 each  0 = read, 1 = write.
REQ-008 master_0_wdata, master_1_wdata  input  32 each  write data.
REQ-009 slave_ack  input  1  slave accepts the presented request.
REQ-010 slave_resp  input  1  slave returns read data (one-cycle pulse).
REQ-011 slave_req  output  1  request to the slave.
REQ-012 slave_addr  output  32, slave_cmd  output  1, slave_wdata  output  32: forwarded fields of the granted master.
REQ-013 master_0_granted, master_1_granted  output  1 each  ownership flag per master; these feed the downstream response router for the same master.
REQ-014 timeout_err  output  1  one-cycle pulse on an aborted transaction.

Function
REQ-015 A master is eligible when master_x_req = 1 and master_x_addr[31] = SLAVE_ID.
REQ-016 The FSM SHALL have the states IDLE, REQ, RESP and HOLD.
REQ-017 IDLE: if any master is eligible, latch winner's addr/cmd/wdata into output registers, set winner's granted, go to REQ; slave_req = 1 from the next cycle.
REQ-018 Arbitration is round-robin: a 1-bit priority pointer names the preferred master; if both are eligible, the pointer's master wins; if one is eligible, it wins.
REQ-019 The pointer SHALL flip to the other master on every transaction completion or abort, only when the loser was eligible at grant time; otherwise unchanged.
REQ-020 REQ: slave_req = 1, outputs frozen; on slave_ack go to RESP if cmd = read, HOLD if cmd = write; slave_req drops in the cycle after ack.
REQ-021 RESP: slave_req = 0; on slave_resp go to HOLD.
REQ-022 HOLD: lasts exactly one cycle; granted stays asserted so a downstream stage that registers granted once and the response once still sees ownership; then IDLE with granted = 0.
REQ-023 Exactly one or zero of master_0_granted/master_1_granted is 1 at any time; granted stays asserted continuously from the cycle after IDLE exit through HOLD.
REQ-024 An 8-bit-or-wider wait counter clears on entering REQ and RESP and increments each cycle there; reaching TIMEOUT in REQ or RESP SHALL go to IDLE, drop slave_req and granted, and pulse timeout_err for one cycle.
REQ-025 slave_ack outside REQ and slave_resp outside RESP SHALL be ignored.
REQ-026 Master request drop during REQ/RESP does not cancel the transaction; the latched fields remain.
REQ-027 New arbitration occurs only in IDLE; minimum grant-to-grant spacing is one IDLE cycle.
REQ-028 slave_addr/slave_cmd/slave_wdata hold the last granted values while IDLE.

Reset
REQ-029 While rst_n = 0, immediately: state IDLE, slave_req 0, both granted 0, timeout_err 0, slave_addr 0, slave_cmd 0, slave_wdata 0, pointer = master 0, counter 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no timeout_err; the first grant after release follows REQ-017 from IDLE.

Verification
REQ-031 Single read: master 0 req, addr 0x0000_0010, cmd 0, SLAVE_ID 0; ack 2 cycles after slave_req, resp 3 cycles later -> master_0_granted high from grant through one cycle after resp, slave_addr 0x0000_0010, no timeout_err.
REQ-032 Collision: both masters eligible in the same IDLE cycle after reset -> master 0 served first, master 1 next; repeat -> master 0 again only after master 1 served.
REQ-033 Address filter: master 1 req with addr 0x8000_0000, SLAVE_ID 0 -> slave_req stays 0, granted stays 0.
REQ-034 Write: master 1 cmd 1, wdata 0xDEAD_BEEF, ack in the first REQ cycle -> slave_wdata 0xDEAD_BEEF, HOLD one cycle, IDLE, no wait for slave_resp.
REQ-035 Timeout: TIMEOUT 4, never ack -> slave_req falls after 4 REQ cycles, timeout_err pulses once, granted 0, pointer flips if the other master was waiting.
REQ-036 Reset in RESP: rst_n low for 1 cycle -> all outputs at REQ-029 values within the same cycle, no timeout_err, a stray slave_resp afterward ignored.

Source files
------------

// File: rtl/slave_arbiter_if.sv
// -----------------------------------------------------------------------------
// slave_arbiter_if
//   Bundles the two master request channels and the slave-side channel that
//   the arbiter sits between.
//
//   Modports:
//     slave  - view of the arbiter itself: consumes master requests and the
//              slave's ack/resp; drives the forwarded request, per-master
//              ownership flags and timeout_err.
//     master - view of the surrounding environment (masters, slave, router).
//
//   Signals:
//     master_0/1_req    request from master 0/1
//     master_0/1_addr   request address, bit 31 selects the slave
//     master_0/1_cmd    0 = read, 1 = write
//     master_0/1_wdata  write data
//     slave_ack         slave accepts the presented request
//     slave_resp        slave returns read data (one-cycle pulse)
//     slave_req         request to the slave
//     slave_addr/cmd/wdata  forwarded fields of the granted master
//     master_0/1_granted    ownership flag per master
//     timeout_err       one-cycle pulse on an aborted transaction
// -----------------------------------------------------------------------------
interface slave_arbiter_if;
    logic        master_0_req;
    logic [31:0] master_0_addr;
    logic        master_0_cmd;
    logic [31:0] master_0_wdata;
    logic        master_1_req;
    logic [31:0] master_1_addr;
    logic        master_1_cmd;
    logic [31:0] master_1_wdata;

    logic        slave_ack;
    logic        slave_resp;
    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;

    logic        master_0_granted;
    logic        master_1_granted;
    logic        timeout_err;

    modport slave (
        input  master_0_req, master_0_addr, master_0_cmd, master_0_wdata,
        input  master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
        input  slave_ack, slave_resp,
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        output master_0_granted, master_1_granted, timeout_err
    );

    modport master (
        output master_0_req, master_0_addr, master_0_cmd, master_0_wdata,
        output master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
        output slave_ack, slave_resp,
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        input  master_0_granted, master_1_granted, timeout_err
    );
endinterface

// File: rtl/slave_arbiter.sv
// -----------------------------------------------------------------------------
// slave_arbiter
//   Two-master, one-slave round-robin arbiter. A master is eligible when it
//   requests and its address bit 31 matches SLAVE_ID. The winner's fields are
//   latched and forwarded; the transaction runs REQ -> (RESP for reads) ->
//   HOLD -> IDLE, or is aborted back to IDLE after TIMEOUT wait cycles.
//
//   Parameters:
//     SLAVE_ID  value of addr[31] this block serves
//     TIMEOUT   max cycles spent waiting in REQ or RESP before abort (>= 1)
//
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    slave_arbiter_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------
module slave_arbiter #(
    parameter int SLAVE_ID = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    slave_arbiter_if.slave    bus
);

    localparam int CNT_W_MIN = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_MIN > 8) ? CNT_W_MIN : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic             SID      = 1'(SLAVE_ID);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e             state_q;
    logic               ptr_q;         // preferred master: 0 or 1
    logic               loser_elig_q;  // losing master was eligible at grant
    logic [CNT_W-1:0]   cnt_q;
    logic               slave_req_q;
    logic [31:0]        slave_addr_q;
    logic               slave_cmd_q;
    logic [31:0]        slave_wdata_q;
    logic               granted_0_q;
    logic               granted_1_q;
    logic               timeout_err_q;

    logic elig_0, elig_1, win_1, any_elig;

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        elig_0   = 1'b0;
        elig_1   = 1'b0;
        elig_0   = bus.master_0_req && (bus.master_0_addr[31] == SID);
        elig_1   = bus.master_1_req && (bus.master_1_addr[31] == SID);
        any_elig = elig_0 || elig_1;
        // Master 1 wins when it alone is eligible, or both are and it is preferred.
        win_1    = elig_1 && (!elig_0 || ptr_q);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    // NOTE: the forwarded data registers are reset as well; they are visible
    // outputs and must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            loser_elig_q  <= 1'b0;
            cnt_q         <= '0;
            slave_req_q   <= 1'b0;
            slave_addr_q  <= '0;
            slave_cmd_q   <= 1'b0;
            slave_wdata_q <= '0;
            granted_0_q   <= 1'b0;
            granted_1_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        slave_addr_q  <= win_1 ? bus.master_1_addr  : bus.master_0_addr;
                        slave_cmd_q   <= win_1 ? bus.master_1_cmd   : bus.master_0_cmd;
                        slave_wdata_q <= win_1 ? bus.master_1_wdata : bus.master_0_wdata;
                        granted_0_q   <= !win_1;
                        granted_1_q   <= win_1;
                        loser_elig_q  <= elig_0 && elig_1;
                        slave_req_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= REQ;
                    end
                end

                REQ: begin
                    if (bus.slave_ack) begin
                        slave_req_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= slave_cmd_q ? HOLD : RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        slave_req_q   <= 1'b0;
                        granted_0_q   <= 1'b0;
                        granted_1_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        ptr_q         <= ptr_q ^ loser_elig_q;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RESP: begin
                    if (bus.slave_resp) begin
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        granted_0_q   <= 1'b0;
                        granted_1_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        ptr_q         <= ptr_q ^ loser_elig_q;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                HOLD: begin
                    // Ownership is kept through this cycle so the response
                    // router can still associate the response with its master.
                    granted_0_q <= 1'b0;
                    granted_1_q <= 1'b0;
                    ptr_q       <= ptr_q ^ loser_elig_q;
                    state_q     <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.slave_req        = slave_req_q;
    assign bus.slave_addr       = slave_addr_q;
    assign bus.slave_cmd        = slave_cmd_q;
    assign bus.slave_wdata      = slave_wdata_q;
    assign bus.master_0_granted = granted_0_q;
    assign bus.master_1_granted = granted_1_q;
    assign bus.timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slave_arbiter
//   Directed bench for slave_arbiter (SLAVE_ID = 0, TIMEOUT = 4). Inputs are
//   changed 1 ns after a rising edge and outputs are observed at that same
//   point, so each step sees the registers produced by the edge just passed.
//   flags = {slave_req, master_0_granted, master_1_granted, timeout_err}.
// -----------------------------------------------------------------------------
module tb_slave_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   terr_seen;

    slave_arbiter_if bus ();

    slave_arbiter #(
        .SLAVE_ID (0),
        .TIMEOUT  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [3:0] flags = {bus.slave_req, bus.master_0_granted,
                        bus.master_1_granted, bus.timeout_err};

    // Counts timeout pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (bus.timeout_err === 1'b1) terr_seen <= terr_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.master_0_req   = 1'b0;
        bus.master_0_addr  = 32'h0;
        bus.master_0_cmd   = 1'b0;
        bus.master_0_wdata = 32'h0;
        bus.master_1_req   = 1'b0;
        bus.master_1_addr  = 32'h0;
        bus.master_1_cmd   = 1'b0;
        bus.master_1_wdata = 32'h0;
        bus.slave_ack      = 1'b0;
        bus.slave_resp     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if (flags !== 4'b0000) begin
            $display("FAIL reset_flags got=%b exp=%b", flags, 4'b0000); bad++;
        end
        total++;
        if ({bus.slave_addr, bus.slave_cmd, bus.slave_wdata} !== 65'h0) begin
            $display("FAIL reset_fields got=%h/%b/%h exp=0/0/0",
                     bus.slave_addr, bus.slave_cmd, bus.slave_wdata); bad++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int t0;
        t0 = terr_seen;
        bus.master_0_req  = 1'b1;
        bus.master_0_addr = 32'h0000_0010;
        bus.master_0_cmd  = 1'b0;
        step();                               // first REQ cycle
        total++;
        if (flags !== 4'b1100 || bus.slave_addr !== 32'h0000_0010) begin
            $display("FAIL rd_grant got=%b/%h exp=1100/00000010", flags, bus.slave_addr); bad++;
        end
        bus.master_0_req = 1'b0;              // drop must not cancel
        step();                               // REQ cycle 2
        step();                               // REQ cycle 3: ack now
        bus.slave_ack = 1'b1;
        total++;
        if (flags !== 4'b1100) begin
            $display("FAIL rd_req_held got=%b exp=%b", flags, 4'b1100); bad++;
        end
        step();                               // RESP
        bus.slave_ack = 1'b0;
        total++;
        if (flags !== 4'b0100) begin
            $display("FAIL rd_resp_state got=%b exp=%b", flags, 4'b0100); bad++;
        end
        step();
        step();                               // resp 3 cycles after ack
        bus.slave_resp = 1'b1;
        step();                               // HOLD
        bus.slave_resp = 1'b0;
        total++;
        if (flags !== 4'b0100) begin
            $display("FAIL rd_hold got=%b exp=%b", flags, 4'b0100); bad++;
        end
        step();                               // IDLE
        total++;
        if (flags !== 4'b0000 || bus.slave_addr !== 32'h0000_0010) begin
            $display("FAIL rd_idle got=%b/%h exp=0000/00000010", flags, bus.slave_addr); bad++;
        end
        total++;
        if (terr_seen !== t0) begin
            $display("FAIL rd_no_timeout got=%0d exp=%0d", terr_seen, t0); bad++;
        end
    endtask

    task automatic test_addr_filter();
        bus.master_1_req  = 1'b1;
        bus.master_1_addr = 32'h8000_0000;
        step();
        step();
        step();
        total++;
        if (flags !== 4'b0000) begin
            $display("FAIL filter got=%b exp=%b", flags, 4'b0000); bad++;
        end
        idle_inputs();
    endtask

    task automatic test_write();
        bus.master_1_req   = 1'b1;
        bus.master_1_addr  = 32'h0000_0044;
        bus.master_1_cmd   = 1'b1;
        bus.master_1_wdata = 32'hDEAD_BEEF;
        step();                               // first REQ cycle, ack here
        total++;
        if (flags !== 4'b1010 || bus.slave_wdata !== 32'hDEAD_BEEF || bus.slave_cmd !== 1'b1) begin
            $display("FAIL wr_grant got=%b/%h/%b exp=1010/deadbeef/1",
                     flags, bus.slave_wdata, bus.slave_cmd); bad++;
        end
        bus.slave_ack    = 1'b1;
        bus.master_1_req = 1'b0;
        step();                               // HOLD, no RESP
        bus.slave_ack = 1'b0;
        total++;
        if (flags !== 4'b0010) begin
            $display("FAIL wr_hold got=%b exp=%b", flags, 4'b0010); bad++;
        end
        step();                               // IDLE
        total++;
        if (flags !== 4'b0000 || bus.slave_wdata !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_idle got=%b/%h exp=0000/deadbeef", flags, bus.slave_wdata); bad++;
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        bus.master_0_req  = 1'b1;
        bus.master_0_addr = 32'h0000_0100;
        bus.master_0_cmd  = 1'b1;
        bus.master_1_req  = 1'b1;
        bus.master_1_addr = 32'h0000_0200;
        bus.master_1_cmd  = 1'b1;
        step();
        total++;
        if (flags !== 4'b1100 || bus.slave_addr !== 32'h0000_0100) begin
            $display("FAIL coll_first got=%b/%h exp=1100/00000100", flags, bus.slave_addr); bad++;
        end
        bus.slave_ack = 1'b1;
        step();                               // HOLD
        bus.slave_ack = 1'b0;
        step();                               // IDLE, one gap cycle
        total++;
        if (flags !== 4'b0000) begin
            $display("FAIL coll_gap got=%b exp=%b", flags, 4'b0000); bad++;
        end
        step();
        total++;
        if (flags !== 4'b1010 || bus.slave_addr !== 32'h0000_0200) begin
            $display("FAIL coll_second got=%b/%h exp=1010/00000200", flags, bus.slave_addr); bad++;
        end
        bus.slave_ack = 1'b1;
        step();
        bus.slave_ack = 1'b0;
        step();
        step();
        total++;
        if (flags !== 4'b1100 || bus.slave_addr !== 32'h0000_0100) begin
            $display("FAIL coll_third got=%b/%h exp=1100/00000100", flags, bus.slave_addr); bad++;
        end
        bus.master_0_req = 1'b0;
        bus.master_1_req = 1'b0;
        bus.slave_ack    = 1'b1;
        step();                               // HOLD; pointer now prefers master 1
        bus.slave_ack = 1'b0;
        step();                               // IDLE
        idle_inputs();
    endtask

    task automatic test_timeout();
        int t0;
        t0 = terr_seen;
        bus.master_0_req  = 1'b1;
        bus.master_0_addr = 32'h0000_0300;
        bus.master_1_req  = 1'b1;
        bus.master_1_addr = 32'h0000_0400;
        step();                               // REQ cycle 1, master 1 preferred
        total++;
        if (flags !== 4'b1010 || bus.slave_addr !== 32'h0000_0400) begin
            $display("FAIL to_grant got=%b/%h exp=1010/00000400", flags, bus.slave_addr); bad++;
        end
        step();
        step();
        step();                               // REQ cycle 4
        total++;
        if (flags !== 4'b1010) begin
            $display("FAIL to_req4 got=%b exp=%b", flags, 4'b1010); bad++;
        end
        step();                               // aborted, IDLE
        total++;
        if (flags !== 4'b0001) begin
            $display("FAIL to_abort got=%b exp=%b", flags, 4'b0001); bad++;
        end
        step();                               // pointer flipped: master 0 granted
        total++;
        if (flags !== 4'b1100 || bus.slave_addr !== 32'h0000_0300) begin
            $display("FAIL to_flip got=%b/%h exp=1100/00000300", flags, bus.slave_addr); bad++;
        end
        total++;
        if (terr_seen !== t0 + 1) begin
            $display("FAIL to_pulses got=%0d exp=%0d", terr_seen, t0 + 1); bad++;
        end
    endtask

    // Continues from the grant left by test_timeout (master 0 read in REQ).
    task automatic test_reset_in_resp();
        int t0;
        t0 = terr_seen;
        bus.master_0_req = 1'b0;
        bus.master_1_req = 1'b0;
        bus.slave_ack    = 1'b1;
        step();                               // RESP
        bus.slave_ack = 1'b0;
        total++;
        if (flags !== 4'b0100) begin
            $display("FAIL rst_pre got=%b exp=%b", flags, 4'b0100); bad++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (flags !== 4'b0000 || bus.slave_addr !== 32'h0 || bus.slave_cmd !== 1'b0) begin
            $display("FAIL rst_async got=%b/%h/%b exp=0000/00000000/0",
                     flags, bus.slave_addr, bus.slave_cmd); bad++;
        end
        step();
        rst_n = 1'b1;
        bus.slave_resp = 1'b1;                // stray response
        step();
        bus.slave_resp = 1'b0;
        step();
        total++;
        if (flags !== 4'b0000 || terr_seen !== t0) begin
            $display("FAIL rst_stray got=%b/%0d exp=0000/%0d", flags, terr_seen, t0); bad++;
        end
        // Pointer was reset to master 0.
        bus.master_0_req  = 1'b1;
        bus.master_0_addr = 32'h0000_0500;
        bus.master_1_req  = 1'b1;
        bus.master_1_addr = 32'h0000_0600;
        step();
        total++;
        if (flags !== 4'b1100 || bus.slave_addr !== 32'h0000_0500) begin
            $display("FAIL rst_ptr got=%b/%h exp=1100/00000500", flags, bus.slave_addr); bad++;
        end
        idle_inputs();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        terr_seen = 0;
        rst_n     = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_addr_filter();
        test_write();
        test_collision();
        test_timeout();
        test_reset_in_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
